// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - two-port arbiter and timing sequencer for the BaseRAM async SRAM
module sram_arbiter #(
  parameter int READ_CYCLES  = 2,
  parameter int WRITE_CYCLES = 2,
  parameter int MAX_CONSEC   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [19:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        dm_req,
  input  logic [19:0] dm_addr,
  input  logic        dm_we,
  input  logic [3:0]  dm_be,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_ack,
  output logic        busy,
  inout  wire  [31:0] base_ram_data,
  output logic [19:0] base_ram_addr,
  output logic [3:0]  base_ram_be_n,
  output logic        base_ram_ce_n,
  output logic        base_ram_oe_n,
  output logic        base_ram_we_n
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RD       = 3'd1;
  localparam logic [2:0] S_WR_SETUP = 3'd2;
  localparam logic [2:0] S_WR       = 3'd3;
  localparam logic [2:0] S_WR_HOLD  = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;

  localparam logic [3:0] RD_LAST = 4'(READ_CYCLES - 1);
  localparam logic [3:0] WR_LAST = 4'(WRITE_CYCLES - 1);
  localparam logic [3:0] MAXC    = 4'(MAX_CONSEC);

  logic [2:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  consec_q, consec_d;
  logic        owner_dm_q, owner_dm_d;
  logic [19:0] addr_q, addr_d;
  logic [3:0]  be_n_q, be_n_d;
  logic        ce_n_q, ce_n_d;
  logic        oe_n_q, oe_n_d;
  logic        we_n_q, we_n_d;
  logic        drive_q, drive_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] dm_rdata_q, dm_rdata_d;
  logic        if_ack_q, if_ack_d;
  logic        dm_ack_q, dm_ack_d;
  logic        busy_q, busy_d;

  // Arbitration in IDLE, then step through the SRAM strobe sequence for the granted access
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    consec_d   = consec_q;
    owner_dm_d = owner_dm_q;
    addr_d     = addr_q;
    be_n_d     = be_n_q;
    ce_n_d     = ce_n_q;
    oe_n_d     = oe_n_q;
    we_n_d     = we_n_q;
    drive_d    = drive_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    if_ack_d   = 1'b0;
    dm_ack_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = 4'd0;
        if (if_req && (!dm_req || consec_q == MAXC)) begin
          owner_dm_d = 1'b0;
          consec_d   = 4'd0;
          addr_d     = if_addr;
          be_n_d     = 4'b0000;
          ce_n_d     = 1'b0;
          oe_n_d     = 1'b0;
          state_d    = S_RD;
        end else if (dm_req) begin
          owner_dm_d = 1'b1;
          // Only count dm wins that actually made fetch wait
          consec_d   = if_req ? consec_q + 4'd1 : 4'd0;
          addr_d     = dm_addr;
          ce_n_d     = 1'b0;
          if (dm_we) begin
            be_n_d  = ~dm_be;
            wdata_d = dm_wdata;
            drive_d = 1'b1;
            state_d = S_WR_SETUP;
          end else begin
            be_n_d  = 4'b0000;
            oe_n_d  = 1'b0;
            state_d = S_RD;
          end
        end
      end
      S_RD: begin
        if (cnt_q == RD_LAST) begin
          ce_n_d  = 1'b1;
          oe_n_d  = 1'b1;
          be_n_d  = 4'hF;
          state_d = S_DONE;
          if (owner_dm_q) begin
            dm_rdata_d = base_ram_data;
            dm_ack_d   = 1'b1;
          end else begin
            if_rdata_d = base_ram_data;
            if_ack_d   = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_WR_SETUP: begin
        we_n_d  = 1'b0;
        cnt_d   = 4'd0;
        state_d = S_WR;
      end
      S_WR: begin
        if (cnt_q == WR_LAST) begin
          we_n_d  = 1'b1;
          state_d = S_WR_HOLD;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_WR_HOLD: begin
        ce_n_d   = 1'b1;
        be_n_d   = 4'hF;
        drive_d  = 1'b0;
        dm_ack_d = owner_dm_q;
        if_ack_d = ~owner_dm_q;
        state_d  = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        ce_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        we_n_d  = 1'b1;
        drive_d = 1'b0;
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and registered pin/output flops; reset drops every strobe and abandons the access
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      consec_q   <= 4'd0;
      owner_dm_q <= 1'b0;
      addr_q     <= 20'd0;
      be_n_q     <= 4'hF;
      ce_n_q     <= 1'b1;
      oe_n_q     <= 1'b1;
      we_n_q     <= 1'b1;
      drive_q    <= 1'b0;
      wdata_q    <= 32'd0;
      if_rdata_q <= 32'd0;
      dm_rdata_q <= 32'd0;
      if_ack_q   <= 1'b0;
      dm_ack_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      consec_q   <= consec_d;
      owner_dm_q <= owner_dm_d;
      addr_q     <= addr_d;
      be_n_q     <= be_n_d;
      ce_n_q     <= ce_n_d;
      oe_n_q     <= oe_n_d;
      we_n_q     <= we_n_d;
      drive_q    <= drive_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
      if_ack_q   <= if_ack_d;
      dm_ack_q   <= dm_ack_d;
      busy_q     <= busy_d;
    end
  end

  assign base_ram_data = drive_q ? wdata_q : 32'bz;
  assign base_ram_addr = addr_q;
  assign base_ram_be_n = be_n_q;
  assign base_ram_ce_n = ce_n_q;
  assign base_ram_oe_n = oe_n_q;
  assign base_ram_we_n = we_n_q;
  assign if_rdata      = if_rdata_q;
  assign if_ack        = if_ack_q;
  assign dm_rdata      = dm_rdata_q;
  assign dm_ack        = dm_ack_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - scoreboard bench for sram_arbiter (default and swept timing)
`timescale 1ns/1ps
module tb_sram_arbiter;

  typedef struct {
    bit          is_dm;
    bit          chk_data;
    logic [31:0] rd;
    int          cyc;
    int          oe;
    int          we;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req [2];
  logic [19:0] if_addr [2];
  logic [31:0] if_rdata [2];
  logic        if_ack [2];
  logic        dm_req [2];
  logic [19:0] dm_addr [2];
  logic        dm_we [2];
  logic [3:0]  dm_be [2];
  logic [31:0] dm_wdata [2];
  logic [31:0] dm_rdata [2];
  logic        dm_ack [2];
  logic        busy [2];
  logic [19:0] ram_addr [2];
  logic [3:0]  ram_be_n [2];
  logic        ce_n [2];
  logic        oe_n [2];
  logic        we_n [2];
  wire  [31:0] bus_a;
  wire  [31:0] bus_b;

  logic [31:0] mem [2][256];
  logic        pre_en = 1'b0;
  int          pre_i = 0;
  logic [7:0]  pre_addr = 8'd0;
  logic [31:0] pre_data = 32'd0;

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t qa[$];
  exp_t qb[$];
  int   oe_lo [2];
  int   we_lo [2];

  always #10 clk = ~clk;

  sram_arbiter #(.READ_CYCLES(2), .WRITE_CYCLES(2), .MAX_CONSEC(4)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req[0]), .if_addr(if_addr[0]), .if_rdata(if_rdata[0]), .if_ack(if_ack[0]),
    .dm_req(dm_req[0]), .dm_addr(dm_addr[0]), .dm_we(dm_we[0]), .dm_be(dm_be[0]),
    .dm_wdata(dm_wdata[0]), .dm_rdata(dm_rdata[0]), .dm_ack(dm_ack[0]), .busy(busy[0]),
    .base_ram_data(bus_a), .base_ram_addr(ram_addr[0]), .base_ram_be_n(ram_be_n[0]),
    .base_ram_ce_n(ce_n[0]), .base_ram_oe_n(oe_n[0]), .base_ram_we_n(we_n[0])
  );

  sram_arbiter #(.READ_CYCLES(4), .WRITE_CYCLES(1), .MAX_CONSEC(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req[1]), .if_addr(if_addr[1]), .if_rdata(if_rdata[1]), .if_ack(if_ack[1]),
    .dm_req(dm_req[1]), .dm_addr(dm_addr[1]), .dm_we(dm_we[1]), .dm_be(dm_be[1]),
    .dm_wdata(dm_wdata[1]), .dm_rdata(dm_rdata[1]), .dm_ack(dm_ack[1]), .busy(busy[1]),
    .base_ram_data(bus_b), .base_ram_addr(ram_addr[1]), .base_ram_be_n(ram_be_n[1]),
    .base_ram_ce_n(ce_n[1]), .base_ram_oe_n(oe_n[1]), .base_ram_we_n(we_n[1])
  );

  // Async SRAM models: drive on ce/oe, latch enabled bytes on clock edges while we_n is low
  assign bus_a = (!ce_n[0] && !oe_n[0]) ? mem[0][ram_addr[0][7:0]] : 32'bz;
  assign bus_b = (!ce_n[1] && !oe_n[1]) ? mem[1][ram_addr[1][7:0]] : 32'bz;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (pre_en) mem[pre_i][pre_addr] <= pre_data;
    for (int b = 0; b < 4; b++) begin
      if (!ce_n[0] && !we_n[0] && !ram_be_n[0][b]) mem[0][ram_addr[0][7:0]][b*8 +: 8] <= bus_a[b*8 +: 8];
      if (!ce_n[1] && !we_n[1] && !ram_be_n[1][b]) mem[1][ram_addr[1][7:0]][b*8 +: 8] <= bus_b[b*8 +: 8];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int rc(int i);
    return (i == 0) ? 2 : 4;
  endfunction

  function automatic int wc(int i);
    return (i == 0) ? 2 : 1;
  endfunction

  task automatic push(input int i, input exp_t e);
    if (i == 0) qa.push_back(e);
    else qb.push_back(e);
  endtask

  // Pop the oldest expectation when either port acks and compare port, data, timing, strobe widths
  task automatic mon(input int i);
    exp_t e;
    bit   have;
    if (!oe_n[i]) oe_lo[i]++;
    if (!we_n[i]) we_lo[i]++;
    if (if_ack[i] && dm_ack[i]) check("dual_ack", 32'd1, 32'd0);
    if (if_ack[i] || dm_ack[i]) begin
      have = (i == 0) ? (qa.size() != 0) : (qb.size() != 0);
      if (!have) begin
        check("unexpected_ack", 32'd1, 32'd0);
      end else begin
        e = (i == 0) ? qa.pop_front() : qb.pop_front();
        check("ack_port_dm", 32'(dm_ack[i]), 32'(e.is_dm));
        if (e.chk_data) check("rdata", e.is_dm ? dm_rdata[i] : if_rdata[i], e.rd);
        check("ack_cycle", 32'(cyc), 32'(e.cyc));
        check("oe_low_cycles", 32'(oe_lo[i]), 32'(e.oe));
        check("we_low_cycles", 32'(we_lo[i]), 32'(e.we));
      end
      oe_lo[i] = 0;
      we_lo[i] = 0;
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        oe_lo[i] = 0;
        we_lo[i] = 0;
      end else begin
        mon(i);
      end
    end
  end

  task automatic preload(input int i, input logic [7:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    pre_en = 1'b1; pre_i = i; pre_addr = a; pre_data = d;
    @(posedge clk); #1;
    pre_en = 1'b0;
  endtask

  // One isolated access: expectation is pushed the cycle the request is raised
  task automatic access(input int i, input bit dm, input bit we, input logic [19:0] a,
                        input logic [3:0] be, input logic [31:0] wd, input logic [31:0] rd);
    exp_t e;
    bit   got;
    @(posedge clk); #1;
    e.is_dm = dm; e.chk_data = !we; e.rd = rd;
    e.cyc = cyc + (we ? wc(i) + 3 : rc(i) + 1);
    e.oe = we ? 0 : rc(i);
    e.we = we ? wc(i) : 0;
    push(i, e);
    if (dm) begin
      dm_addr[i] = a; dm_we[i] = we; dm_be[i] = be; dm_wdata[i] = wd; dm_req[i] = 1'b1;
    end else begin
      if_addr[i] = a; if_req[i] = 1'b1;
    end
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if ((dm && dm_ack[i]) || (!dm && if_ack[i])) got = 1'b1;
    end
    check("access_ack_seen", 32'(got), 32'd1);
    @(posedge clk); #1;
    dm_req[i] = 1'b0;
    if_req[i] = 1'b0;
  endtask

  task automatic wait_acks(input int i, input int n);
    int seen;
    seen = 0;
    for (int k = 0; k < 200 && seen < n; k++) begin
      @(negedge clk);
      if (if_ack[i] || dm_ack[i]) seen++;
    end
    check("ack_count", 32'(seen), 32'(n));
    @(posedge clk); #1;
    dm_req[i] = 1'b0;
    if_req[i] = 1'b0;
  endtask

  initial begin
    exp_t e;
    int   c;
    #2000000;
    $display("FAIL global_timeout cycle=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    int   c;
    for (int i = 0; i < 2; i++) begin
      if_req[i] = 1'b0; if_addr[i] = 20'd0; dm_req[i] = 1'b0; dm_addr[i] = 20'd0;
      dm_we[i] = 1'b0; dm_be[i] = 4'h0; dm_wdata[i] = 32'd0; oe_lo[i] = 0; we_lo[i] = 0;
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("rst_ce_n", 32'(ce_n[i]), 32'd1);
      check("rst_oe_n", 32'(oe_n[i]), 32'd1);
      check("rst_we_n", 32'(we_n[i]), 32'd1);
      check("rst_be_n", 32'(ram_be_n[i]), 32'hF);
      check("rst_addr", 32'(ram_addr[i]), 32'd0);
      check("rst_busy", 32'(busy[i]), 32'd0);
      check("rst_acks", 32'({if_ack[i], dm_ack[i]}), 32'd0);
      check("rst_if_rdata", if_rdata[i], 32'd0);
      check("rst_dm_rdata", dm_rdata[i], 32'd0);
    end

    // Fetch-only read, then byte-masked write and read-back through the data port
    preload(0, 8'h10, 32'hDEADBEEF);
    preload(0, 8'h20, 32'hAABBCCDD);
    access(0, 1'b0, 1'b0, 20'h00010, 4'h0, 32'h0, 32'hDEADBEEF);
    access(0, 1'b1, 1'b1, 20'h00020, 4'b0101, 32'h11223344, 32'h0);
    access(0, 1'b1, 1'b0, 20'h00020, 4'h0, 32'h0, 32'hAA22CC44);
    check("if_rdata_held", if_rdata[0], 32'hDEADBEEF);

    // Both ports held: dm wins four times, then fetch is forced
    preload(0, 8'h30, 32'h0BADF00D);
    preload(0, 8'h40, 32'hCAFE0001);
    @(posedge clk); #1;
    c = cyc;
    for (int k = 0; k < 10; k++) begin
      e.is_dm = (k % 5) != 4; e.chk_data = 1'b1;
      e.rd = e.is_dm ? 32'h0BADF00D : 32'hCAFE0001;
      e.cyc = c + 3 + 4 * k; e.oe = 2; e.we = 0;
      qa.push_back(e);
    end
    dm_addr[0] = 20'h00030; dm_we[0] = 1'b0; if_addr[0] = 20'h00040;
    dm_req[0] = 1'b1; if_req[0] = 1'b1;
    wait_acks(0, 10);

    // Back-to-back data reads with the request never dropped
    @(posedge clk); #1;
    c = cyc;
    for (int k = 0; k < 3; k++) begin
      e.is_dm = 1'b1; e.chk_data = 1'b1; e.rd = 32'hAA22CC44;
      e.cyc = c + 3 + 4 * k; e.oe = 2; e.we = 0;
      qa.push_back(e);
    end
    dm_addr[0] = 20'h00020; dm_we[0] = 1'b0; dm_req[0] = 1'b1;
    wait_acks(0, 3);

    // Reset while we_n is low: strobes must release at once and no ack may follow
    @(posedge clk); #1;
    dm_addr[0] = 20'h00050; dm_we[0] = 1'b1; dm_be[0] = 4'hF; dm_wdata[0] = 32'h5A5A5A5A;
    dm_req[0] = 1'b1;
    @(posedge clk);
    @(posedge clk); #2;
    check("pre_rst_we_n", 32'(we_n[0]), 32'd0);
    rst_n = 1'b0;
    #1;
    check("async_rst_we_n", 32'(we_n[0]), 32'd1);
    check("async_rst_ce_n", 32'(ce_n[0]), 32'd1);
    check("async_rst_be_n", 32'(ram_be_n[0]), 32'hF);
    check("async_rst_busy", 32'(busy[0]), 32'd0);
    @(posedge clk); #1;
    dm_req[0] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("post_rst_busy", 32'(busy[0]), 32'd0);
    check("post_rst_ce_n", 32'(ce_n[0]), 32'd1);
    check("post_rst_no_pending", 32'(qa.size()), 32'd0);

    // Swept timing instance: 4-cycle reads, 1-cycle writes
    preload(1, 8'h05, 32'h12345678);
    access(1, 1'b1, 1'b0, 20'h00005, 4'h0, 32'h0, 32'h12345678);
    access(1, 1'b1, 1'b1, 20'h00006, 4'hF, 32'h55667788, 32'h0);
    access(1, 1'b0, 1'b0, 20'h00006, 4'h0, 32'h0, 32'h55667788);
    check("b_dm_rdata_held", dm_rdata[1], 32'h12345678);

    repeat (4) @(posedge clk);
    check("drain_a", 32'(qa.size()), 32'd0);
    check("drain_b", 32'(qb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
